imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Controller that owns the address/write port of the 32-bit word-addressed instruction memory.
- Streams a program in as bytes through a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially from word 0.
- Holds the single-cycle CPU in stall while loading, then returns the memory address port to the CPU fetch path (PC byte address >> 2).

Parameters:
- ADDR_W, 4, word-address width; memory depth = 2**ADDR_W words.
- LOAD_WORDS, 16, number of words in a full program image; must be 1..2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse requesting a program load.
- byte_in  input  8  incoming program byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  controller accepts byte this cycle; transfer when valid and ready both high.
- cpu_pc  input  32  CPU program counter, byte address.
- cpu_stall  output  1  CPU must hold PC and state.
- mem_addr  output  ADDR_W  word address to instruction memory.
- mem_we  output  1  write strobe to instruction memory (registered).
- mem_wdata  output  32  write data.
- load_done  output  1  one-cycle pulse when the final word has been written.

Behaviour:
- Reset values: state IDLE; byte_ready=0, cpu_stall=0, mem_we=0, mem_wdata=0, load_done=0; byte counter=0, word counter=0.
- States:
  - IDLE: byte_ready=0, cpu_stall=0, mem_addr=cpu_pc[ADDR_W+1:2]; cpu_pc[1:0] ignored; upper PC bits beyond ADDR_W+1 ignored (wrap-around). On load_start -> LOAD, clear counters, cpu_stall=1 from next cycle.
  - LOAD: byte_ready=1, cpu_stall=1. Each accepted byte goes to lane byte_cnt (byte 0 -> bits 7:0, ..., byte 3 -> bits 31:24); byte_cnt increments mod 4. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle. mem_we=1, mem_addr=word_cnt, mem_wdata=assembled word, byte_ready=0. word_cnt increments. If new word_cnt==LOAD_WORDS -> DONE, else -> LOAD.
  - DONE: one cycle. load_done=1, cpu_stall=1, mem_we=0 -> IDLE. cpu_stall deasserts the following cycle.
- Write latency: 4th byte accepted at edge N; mem_we high during cycle N+1; write commits at edge N+1.
- Outside WRITE, mem_addr is cpu_pc-derived in IDLE and word_cnt in LOAD/DONE. mem_we is never high outside WRITE.
- byte_valid low in LOAD: wait indefinitely; partial word retained.
- byte_valid while byte_ready=0: ignored; no data loss is the sender's responsibility.
- load_start outside IDLE: ignored, no restart.
- reset mid-load: immediate return to reset values on the same edge; partially written memory content is left as-is; partial word discarded.
- Counters: byte_cnt 2 bits; word_cnt ADDR_W+1 bits so LOAD_WORDS=2**ADDR_W terminates without overflow.

Optional Feature:
- IMEM_LOAD_CHECKSUM_EN
  - Defined:
    - Adds output load_err (1 bit, reset 0).
    - A 32-bit modulo-2**32 sum of all written words accumulates in WRITE.
    - After the last word, state CHECK accepts one extra 4-byte little-endian word (same handshake), then compares it to the sum. load_err is set to 1 if they differ, else 0, and is held until the next load_start or reset. DONE follows CHECK.
  - Undefined: no load_err port, no CHECK state, no extra bytes consumed.

Test Plan:
- Reset then IDLE, cpu_pc=0x0000_0008 -> mem_addr=2, cpu_stall=0, mem_we=0, byte_ready=0.
- load_start; bytes 0x78,0x56,0x34,0x12 with byte_valid held high -> the next cycle has mem_we=1, mem_addr=0, mem_wdata=0x1234_5678; cpu_stall=1 throughout.
- Full 16-word load with byte_valid deasserted for 3 cycles mid-word -> exactly 16 writes at addresses 0..15; load_done single pulse; cpu_stall=0 two cycles after the last write; then cpu_pc=0x3C -> mem_addr=15.
- reset asserted after 6 bytes -> all outputs return to reset values next cycle; a new load_start begins at word 0 with byte_cnt 0.
- load_start pulsed during LOAD -> ignored; word_cnt unchanged; cpu_pc=0xFFFF_FFF4 in IDLE -> mem_addr=13.
- With IMEM_LOAD_CHECKSUM_EN: load words 1..16 then checksum 136 (0x88) -> load_err=0; repeat with checksum 0x89 -> load_err=1 and held until next load_start.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_ctrl_if
// Brief    : Byte-stream, CPU fetch and instruction-memory write signals of
//            the instruction-memory load controller, grouped in one bundle.
//            load_err exists only when IMEM_LOAD_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_load_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              load_start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [31:0]       cpu_pc;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              load_done;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic              load_err;
`endif

  // System side: byte source, CPU and memory observer
  modport master (
    output load_start, byte_in, byte_valid, cpu_pc,
    input  byte_ready, cpu_stall, mem_addr, mem_we, mem_wdata, load_done
`ifdef IMEM_LOAD_CHECKSUM_EN
    , input load_err
`endif
  );

  // Controller side
  modport slave (
    input  load_start, byte_in, byte_valid, cpu_pc,
    output byte_ready, cpu_stall, mem_addr, mem_we, mem_wdata, load_done
`ifdef IMEM_LOAD_CHECKSUM_EN
    , output load_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_ctrl
// Brief    : Owns the instruction-memory address/write port. Streams a
//            program in as bytes, packs little-endian 32-bit words, writes
//            them from word 0 upward while stalling the CPU, then hands the
//            address port back to the CPU fetch path (PC >> 2).
//            Optional macro IMEM_LOAD_CHECKSUM_EN adds a trailing checksum
//            word and the load_err output.
// Revision : 1.0 - initial release
// ============================================================================
module imem_load_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int LOAD_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  imem_load_ctrl_if.slave   bus
);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`endif

  // One extra bit so a full-depth image terminates without wrapping to 0
  localparam logic [ADDR_W:0] c_LOAD_WORDS = (ADDR_W+1)'(LOAD_WORDS);
  localparam logic [ADDR_W:0] c_WORD_ONE   = (ADDR_W+1)'(1);

  state_t            r_state;
  logic              r_byte_ready;
  logic              r_cpu_stall;
  logic              r_mem_we;
  logic [31:0]       r_mem_wdata;
  logic              r_load_done;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_word_cnt;
  // Lanes 0..2 of the word being assembled; lane 3 comes straight from byte_in
  logic [23:0]       r_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]       r_sum;
  logic              r_load_err;
`endif

  logic              w_xfer;
  logic [31:0]       w_word_full;
  logic [ADDR_W:0]   w_word_cnt_nxt;
  logic              w_unused_pc;

  assign w_xfer         = bus.byte_valid & r_byte_ready;
  assign w_word_full    = {bus.byte_in, r_word};
  assign w_word_cnt_nxt = r_word_cnt + c_WORD_ONE;
  // Byte offset and PC bits above the memory depth are deliberately dropped
  assign w_unused_pc    = ^{bus.cpu_pc[31:ADDR_W+2], bus.cpu_pc[1:0]};

  // CPU fetch owns the address port only while idle
  assign bus.mem_addr   = (r_state == S_IDLE) ? bus.cpu_pc[ADDR_W+1:2]
                                              : r_word_cnt[ADDR_W-1:0];
  assign bus.byte_ready = r_byte_ready;
  assign bus.cpu_stall  = r_cpu_stall;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.load_done  = r_load_done;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign bus.load_err   = r_load_err;
`endif

  // Load sequencer: byte assembly, word writes and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_cpu_stall  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= 32'd0;
      r_load_done  <= 1'b0;
      r_byte_cnt   <= 2'd0;
      r_word_cnt   <= '0;
      r_word       <= 24'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      r_sum        <= 32'd0;
      r_load_err   <= 1'b0;
`endif
    end else begin
      // Strobes default low; only the transitions below raise them
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;

      // Lane placement for bytes 0..2 in both LOAD and CHECK
      if (w_xfer) begin
        case (r_byte_cnt)
          2'd0:    r_word[7:0]   <= bus.byte_in;
          2'd1:    r_word[15:8]  <= bus.byte_in;
          2'd2:    r_word[23:16] <= bus.byte_in;
          default: ;
        endcase
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_cpu_stall <= 1'b0;
          if (bus.load_start) begin
            r_state      <= S_LOAD;
            r_byte_ready <= 1'b1;
            r_cpu_stall  <= 1'b1;
            r_byte_cnt   <= 2'd0;
            r_word_cnt   <= '0;
            r_word       <= 24'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_sum        <= 32'd0;
            r_load_err   <= 1'b0;
`endif
          end
        end

        S_LOAD: begin
          if (w_xfer && (r_byte_cnt == 2'd3)) begin
            r_mem_wdata  <= w_word_full;
            r_mem_we     <= 1'b1;
            r_byte_ready <= 1'b0;
            r_state      <= S_WRITE;
          end
        end

        S_WRITE: begin
          r_word_cnt <= w_word_cnt_nxt;
`ifdef IMEM_LOAD_CHECKSUM_EN
          r_sum      <= r_sum + r_mem_wdata;
`endif
          if (w_word_cnt_nxt == c_LOAD_WORDS) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_state      <= S_CHECK;
            r_byte_ready <= 1'b1;
`else
            r_state      <= S_DONE;
            r_load_done  <= 1'b1;
`endif
          end else begin
            r_state      <= S_LOAD;
            r_byte_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOAD_CHECKSUM_EN
        S_CHECK: begin
          if (w_xfer && (r_byte_cnt == 2'd3)) begin
            r_load_err   <= (w_word_full != r_sum);
            r_byte_ready <= 1'b0;
            r_load_done  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          r_state     <= S_IDLE;
          r_cpu_stall <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_cpu_stall  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_load_ctrl
// Brief    : Self-checking bench for imem_load_ctrl. Expected memory writes
//            are queued as bytes are driven and compared when mem_we rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;
  localparam int ADDR_W     = 4;
  localparam int LOAD_WORDS = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int total    = 0;
  int bad      = 0;
  int n_writes = 0;
  int n_done   = 0;

  logic [35:0] exp_q[$];
  logic [35:0] r_exp;

  imem_load_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  imem_load_ctrl #(.ADDR_W(ADDR_W), .LOAD_WORDS(LOAD_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every write strobe must match the next queued word
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_we) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          r_exp = exp_q.pop_front();
          check("wr_addr",  64'(bus.mem_addr),   64'(r_exp[35:32]));
          check("wr_data",  64'(bus.mem_wdata),  64'(r_exp[31:0]));
          check("wr_stall", 64'(bus.cpu_stall),  64'd1);
          check("wr_ready", 64'(bus.byte_ready), 64'd0);
        end
      end
      if (bus.load_done) n_done++;
    end
  end

  task automatic pulse_start();
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  // Present one byte and hold it until the posedge that accepts it
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", 64'd0, 64'd1);
    check("load_stall", 64'(bus.cpu_stall), 64'd1);
    @(negedge clk);
  endtask

  task automatic full_load(input bit seq, input logic [31:0] delta);
    logic [31:0] w;
    logic [31:0] s;
    int w0;
    int d0;
    int k;
    s  = 32'd0;
    w0 = n_writes;
    d0 = n_done;
    pulse_start();
    for (int i = 0; i < LOAD_WORDS; i++) begin
      w = seq ? 32'(i + 1) : $urandom;
      s = s + w;
      exp_q.push_back({i[3:0], w});
      for (int b = 0; b < 4; b++) begin
        send_byte(w[8*b +: 8]);
        if (i == 5 && b == 1) begin
          bus.byte_valid = 1'b0;
          repeat (3) begin
            @(negedge clk);
            check("gap_stall", 64'(bus.cpu_stall),  64'd1);
            check("gap_we",    64'(bus.mem_we),     64'd0);
            check("gap_ready", 64'(bus.byte_ready), 64'd1);
          end
        end
        if (i == 8 && b == 1) begin
          bus.byte_valid = 1'b0;
          pulse_start();
        end
      end
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    w = s + delta;
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
`endif
    bus.byte_valid = 1'b0;
    k = 0;
    while (!bus.load_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("done_seen",  64'(bus.load_done), 64'd1);
    check("done_stall", 64'(bus.cpu_stall), 64'd1);
    check("done_we",    64'(bus.mem_we),    64'd0);
    @(negedge clk);
    check("stall_release", 64'(bus.cpu_stall),   64'd0);
    check("done_pulse",    64'(bus.load_done),   64'd0);
    check("done_count",    64'(n_done - d0),     64'd1);
    check("write_count",   64'(n_writes - w0),   64'(LOAD_WORDS));
    check("queue_empty",   64'(exp_q.size()),    64'd0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("load_err", 64'(bus.load_err), 64'(delta != 32'd0));
`endif
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.byte_in    = 8'd0;
    bus.byte_valid = 1'b0;
    bus.cpu_pc     = 32'h0000_0008;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_addr",  64'(bus.mem_addr),   64'd2);
    check("rst_stall", 64'(bus.cpu_stall),  64'd0);
    check("rst_we",    64'(bus.mem_we),     64'd0);
    check("rst_ready", 64'(bus.byte_ready), 64'd0);
    check("rst_done",  64'(bus.load_done),  64'd0);
    check("rst_wdata", 64'(bus.mem_wdata),  64'd0);

    // First word then reset after six bytes
    pulse_start();
    exp_q.push_back({4'd0, 32'h1234_5678});
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 64'(bus.byte_ready), 64'd0);
    check("mid_rst_stall", 64'(bus.cpu_stall),  64'd0);
    check("mid_rst_we",    64'(bus.mem_we),     64'd0);
    check("mid_rst_wdata", 64'(bus.mem_wdata),  64'd0);
    check("mid_rst_done",  64'(bus.load_done),  64'd0);
    check("mid_rst_addr",  64'(bus.mem_addr),   64'd2);
    check("first_word_q",  64'(exp_q.size()),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full image with a stall gap and an ignored restart request
    full_load(1'b0, 32'd0);

    bus.cpu_pc = 32'h0000_003C;
    #1;
    check("pc_3c", 64'(bus.mem_addr), 64'd15);
    bus.cpu_pc = 32'hFFFF_FFF4;
    #1;
    check("pc_wrap", 64'(bus.mem_addr), 64'd13);
    @(negedge clk);

`ifdef IMEM_LOAD_CHECKSUM_EN
    full_load(1'b1, 32'd0);
    full_load(1'b1, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("err_held", 64'(bus.load_err), 64'd1);
    end
    pulse_start();
    check("err_clear", 64'(bus.load_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
